// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer.
// Optional down counting is enabled with the COUNTER_SEQUENCER_DOWN_EN macro.
package counter_sequencer_pkg;

  // Default width of the count register.
  localparam int DEFAULT_WIDTH = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // busy is high while a run is in progress, including while paused.
  function automatic logic is_busy(input state_t s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/count_reg.sv
// Count datapath: synchronous clear, load, and modulo increment/decrement.
// The load input wins over enable. The down input is driven only when
// COUNTER_SEQUENCER_DOWN_EN is defined; otherwise it is tied low.
module count_reg
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_step;

  // Next count value; wrap-around comes for free from the fixed width.
  always_comb begin
    count_step = count + ONE;
    if (down) begin
      count_step = count - ONE;
    end
  end

  // Count register: clear has priority over load, and load over advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count_step;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer top: run/pause/done FSM, start-time capture registers,
// and the registered busy and done outputs. The count datapath is count_reg.
// Defining COUNTER_SEQUENCER_DOWN_EN adds the dir port for down counting.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             tick,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
`ifdef COUNTER_SEQUENCER_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] load_q;
  logic             reload_q;
  logic             capture;
  logic             cnt_clear;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_value;
  logic             cnt_enable;
  logic             cnt_down;
  logic             done_next;
  logic             at_limit;

`ifdef COUNTER_SEQUENCER_DOWN_EN
  logic             dir_q;

  // Direction is captured at start, like the other run parameters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q <= 1'b0;
    end else if (capture) begin
      dir_q <= dir;
    end
  end

  assign cnt_down = dir_q;
`else
  assign cnt_down = 1'b0;
`endif

  assign at_limit = (count == limit_q);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath controls; stop beats pause, pause beats tick,
  // and stop beats start.
  always_comb begin
    state_next     = state;
    capture        = 1'b0;
    cnt_clear      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = load_val;
    cnt_enable     = 1'b0;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (!stop && start) begin
          state_next = RUN;
          capture    = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (pause) begin
          state_next = PAUSE;
        end else if (tick) begin
          if (at_limit) begin
            done_next = 1'b1;
            if (reload_q) begin
              cnt_load       = 1'b1;
              cnt_load_value = load_q;
            end else begin
              state_next = DONE;
            end
          end else begin
            cnt_enable = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (start) begin
          state_next = RUN;
          capture    = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Run parameters held for the whole run so the inputs may change freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      limit_q  <= '0;
      load_q   <= '0;
      reload_q <= 1'b0;
    end else if (capture) begin
      limit_q  <= limit;
      load_q   <= load_val;
      reload_q <= auto_reload;
    end
  end

  // Registered status outputs: done is a one-cycle pulse after terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= is_busy(state_next);
      done <= done_next;
    end
  end

  count_reg #(
    .WIDTH(WIDTH)
  ) u_count_reg (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .enable    (cnt_enable),
    .down      (cnt_down),
    .count     (count)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: directed scenarios plus random stimulus,
// checked by a scoreboard against a behavioural model.
module tb_counter_sequencer;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int    step;
    int    count;
    int    busy;
    int    done;
    string tag;
  } expect_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic         pause;
  logic         tick;
  logic         auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic         dir;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  expect_t exp_q[$];
  int      checks;
  int      errors;
  int      step_no;
  string   cur_tag;

  int m_mode;
  int m_count;
  int m_load;
  int m_limit;
  bit m_reload;
  bit m_down;
  int m_done;

  counter_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .tick       (tick),
    .auto_reload(auto_reload),
    .load_val   (load_val),
    .limit      (limit),
`ifdef COUNTER_SEQUENCER_DOWN_EN
    .dir        (dir),
`endif
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    m_mode   = M_IDLE;
    m_count  = 0;
    m_load   = 0;
    m_limit  = 0;
    m_reload = 0;
    m_down   = 0;
    m_done   = 0;
  endfunction

  function automatic void model_begin(input bit ar, input int lv, input int lim, input bit dr);
    m_mode   = M_RUN;
    m_count  = lv;
    m_load   = lv;
    m_limit  = lim;
    m_reload = ar;
`ifdef COUNTER_SEQUENCER_DOWN_EN
    m_down   = dr;
`else
    m_down   = 0;
    if (dr) m_down = 0;
`endif
  endfunction

  function automatic void model_abort();
    m_mode  = M_IDLE;
    m_count = 0;
  endfunction

  // One clock of the reference behaviour, from the requirements' rules.
  function automatic void model_step(input bit st, input bit sp, input bit ps, input bit tk,
                                     input bit ar, input int lv, input int lim, input bit dr);
    m_done = 0;
    if (m_mode == M_IDLE) begin
      if (!sp && st) model_begin(ar, lv, lim, dr);
    end else if (m_mode == M_RUN) begin
      if (sp) model_abort();
      else if (ps) m_mode = M_PAUSE;
      else if (tk) begin
        if (m_count == m_limit) begin
          m_done = 1;
          if (m_reload) m_count = m_load;
          else m_mode = M_DONE;
        end else if (m_down) begin
          m_count = (m_count + MOD - 1) % MOD;
        end else begin
          m_count = (m_count + 1) % MOD;
        end
      end
    end else if (m_mode == M_PAUSE) begin
      if (sp) model_abort();
      else if (!ps) m_mode = M_RUN;
    end else begin
      if (sp) model_abort();
      else if (st) model_begin(ar, lv, lim, dr);
    end
  endfunction

  function automatic void push_expect();
    expect_t e;
    e.step  = step_no;
    e.count = m_count;
    e.busy  = (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0;
    e.done  = m_done;
    e.tag   = cur_tag;
    exp_q.push_back(e);
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic apply_stimulus(input bit st, input bit sp, input bit ps, input bit tk,
                                input bit ar, input int lv, input int lim, input bit dr);
    @(negedge clk);
    #1;
    start       = st;
    stop        = sp;
    pause       = ps;
    tick        = tk;
    auto_reload = ar;
    load_val    = W'(lv);
    limit       = W'(lim);
    dir         = dr;
    model_step(st, sp, ps, tk, ar, lv, lim, dr);
    @(posedge clk);
    #1;
    step_no++;
    push_expect();
  endtask

  // Monitor: compare every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        expect_t e;
        e = exp_q.pop_front();
        check_output($sformatf("%s.count@%0d", e.tag, e.step), int'(count), e.count);
        check_output($sformatf("%s.busy@%0d", e.tag, e.step), int'(busy), e.busy);
        check_output($sformatf("%s.done@%0d", e.tag, e.step), int'(done), e.done);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    cur_tag = "reset";
    model_reset();
    reset       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    pause       = 1'b0;
    tick        = 1'b0;
    auto_reload = 1'b0;
    load_val    = '0;
    limit       = '0;
    dir         = 1'b0;
    #12;
    check_output("reset_count", int'(count), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // One-shot: 3,4,5,6 then a single done, then DONE holding 6.
    cur_tag = "oneshot";
    apply_stimulus(1, 0, 0, 1, 0, 3, 6, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    check_output("oneshot_final_count", int'(count), 6);
    check_output("oneshot_final_done", int'(done), 1);
    check_output("oneshot_final_busy", int'(busy), 0);
    for (int i = 0; i < 2; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    check_output("oneshot_hold_count", int'(count), 6);
    check_output("oneshot_hold_done", int'(done), 0);

    // Wrap: start from DONE, 14,15,0,1 then done.
    cur_tag = "wrap";
    apply_stimulus(1, 0, 0, 1, 0, 14, 1, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);

    // Auto-reload: 0,1,2,0,1,2 with done every third cycle.
    cur_tag = "reload";
    apply_stimulus(1, 0, 0, 1, 1, 0, 2, 0);
    for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    check_output("reload_busy", int'(busy), 1);

    // Stop together with start in RUN: back to IDLE, start ignored.
    cur_tag = "stopstart";
    apply_stimulus(1, 1, 0, 1, 0, 9, 9, 0);
    check_output("stopstart_count", int'(count), 0);
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);

    // Load equal to limit: done on the first qualified tick.
    cur_tag = "loadeqlimit";
    apply_stimulus(1, 0, 0, 0, 0, 7, 7, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);

    // Pause for five cycles mid-run with alternating tick.
    cur_tag = "pause";
    apply_stimulus(1, 0, 0, 0, 0, 0, 12, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, bit'(i % 2 == 0), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, bit'(i % 2 == 0), 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);

`ifdef COUNTER_SEQUENCER_DOWN_EN
    // Down count: 1,0,15,14 then done.
    cur_tag = "down";
    apply_stimulus(1, 0, 0, 1, 0, 1, 14, 1);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);
`endif

    // Reset mid-run at count 5: immediate clear, no done pulse afterwards.
    cur_tag = "midreset";
    apply_stimulus(1, 0, 0, 1, 0, 2, 9, 0);
    while (m_count != 5) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("midreset_count", int'(count), 0);
    check_output("midreset_busy", int'(busy), 0);
    check_output("midreset_done", int'(done), 0);
    model_reset();
    @(posedge clk);
    #1;
    step_no++;
    push_expect();
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, 4, 5, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);

    // Random traffic.
    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      int lv;
      int lim;
      lv  = int'($urandom_range(0, MOD - 1));
      lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MOD - 1))
                                        : (lv + int'($urandom_range(0, 5))) % MOD;
      apply_stimulus(bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 24) == 0),
                     bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 9) < 7),
                     bit'($urandom_range(0, 1)), lv, lim, bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    @(negedge clk);
    check_output("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
